multi_input_sequencer: RTL and testbench

MULTI_INPUT_SEQUENCER -- requirements
Module: multi_input_sequencer

---
 rtl/multi_input_sequencer_if.sv | 32 +++
 rtl/multi_input_sequencer.sv | 174 +++++++++++++++++
 tb/tb_multi_input_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_input_sequencer_if.sv
// Control/status bundle for the multi-input fluid sequencer.
// The master drives start, abort and the phase setup; the slave drives the actuator and status outputs.
interface multi_input_sequencer_if #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 16
);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             start;
  logic             abort;
  logic [N_CH-1:0]  ch_en;
  logic [CNT_W-1:0] load_cycles;
  logic [CNT_W-1:0] mix_cycles;
  logic [CNT_W-1:0] hold_cycles;
  logic [N_CH-1:0]  valve_open;
  logic             mix_en;
  logic             trap_open;
  logic [IDX_W-1:0] cur_ch;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, abort, ch_en, load_cycles, mix_cycles, hold_cycles,
    input  valve_open, mix_en, trap_open, cur_ch, busy, done, err
  );

  modport slave (
    input  start, abort, ch_en, load_cycles, mix_cycles, hold_cycles,
    output valve_open, mix_en, trap_open, cur_ch, busy, done, err
  );
endinterface

// File: rtl/multi_input_sequencer.sv
// Break-before-make valve sequencer: GAP/LOAD per enabled channel, then GAP, MIX, RELEASE, DONE.
// Outputs are registered and take effect the cycle after the edge that samples start/abort; no backpressure.
module multi_input_sequencer #(
  parameter int N_CH    = 3,
  parameter int CNT_W   = 16,
  parameter int MIN_GAP = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multi_input_sequencer_if.slave  bus
);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] GAP_CNT = CNT_W'(MIN_GAP);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_LOAD, S_MIX, S_RELEASE, S_DONE, S_ABORT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]  rem_q, rem_d;
  logic [IDX_W-1:0] ch_q, ch_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] mix_q, mix_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             err_d;

  logic [N_CH-1:0]  valve_q;
  logic             mix_en_q, trap_q, busy_q, done_q, err_q;

  logic [IDX_W-1:0] nxt_ch;
  logic             nxt_vld;
  logic             last;

  always_comb begin
    nxt_ch  = '0;
    nxt_vld = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rem_q[i]) begin
        nxt_ch  = IDX_W'(i);
        nxt_vld = 1'b1;
      end
    end
  end

  // Timed states are only ever entered with a non-zero count, so the
  // counter ends a phase at 1 and never reaches 0 or wraps.
  assign last = (cnt_q <= CNT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    ch_d    = ch_q;
    load_d  = load_q;
    mix_d   = mix_q;
    hold_d  = hold_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          if (bus.ch_en != '0) begin
            rem_d   = bus.ch_en;
            load_d  = bus.load_cycles;
            mix_d   = bus.mix_cycles;
            hold_d  = bus.hold_cycles;
            state_d = S_GAP;
            cnt_d   = GAP_CNT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (!last) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (nxt_vld) begin
          ch_d  = nxt_ch;
          rem_d = rem_q & ~(N_CH'(1) << nxt_ch);
          if (load_q != '0) begin
            state_d = S_LOAD;
            cnt_d   = load_q;
          end else begin
            state_d = S_GAP;
            cnt_d   = GAP_CNT;
          end
        end else if (mix_q != '0) begin
          state_d = S_MIX;
          cnt_d   = mix_q;
        end else if (hold_q != '0) begin
          state_d = S_RELEASE;
          cnt_d   = hold_q;
        end else begin
          state_d = S_DONE;
        end
      end
      S_LOAD: begin
        if (last) begin
          state_d = S_GAP;
          cnt_d   = GAP_CNT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_MIX: begin
        if (!last) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (hold_q != '0) begin
          state_d = S_RELEASE;
          cnt_d   = hold_q;
        end else begin
          state_d = S_DONE;
        end
      end
      S_RELEASE: begin
        if (last) state_d = S_DONE;
        else      cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DONE: state_d = S_IDLE;
      S_ABORT: begin
        if (last) state_d = S_IDLE;
        else      cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // A running abort phase is not restarted by a held abort.
    if (bus.abort && state_q != S_IDLE && state_q != S_ABORT) begin
      state_d = S_ABORT;
      cnt_d   = GAP_CNT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      ch_q     <= '0;
      load_q   <= '0;
      mix_q    <= '0;
      hold_q   <= '0;
      valve_q  <= '0;
      mix_en_q <= 1'b0;
      trap_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      ch_q     <= ch_d;
      load_q   <= load_d;
      mix_q    <= mix_d;
      hold_q   <= hold_d;
      valve_q  <= (state_d == S_LOAD) ? (N_CH'(1) << ch_d) : '0;
      mix_en_q <= (state_d == S_MIX);
      trap_q   <= (state_d == S_RELEASE);
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
      err_q    <= err_d;
    end
  end

  assign bus.valve_open = valve_q;
  assign bus.mix_en     = mix_en_q;
  assign bus.trap_open  = trap_q;
  assign bus.cur_ch     = ch_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_multi_input_sequencer.sv
// Randomized bench: each sequence is expanded into an expected per-cycle output trace
// from the phase rules, then compared cycle by cycle together with the valve safety invariants.
module tb_multi_input_sequencer;
  localparam int N_CH    = 3;
  localparam int CNT_W   = 16;
  localparam int MIN_GAP = 2;

  typedef struct packed {
    logic [N_CH-1:0] valve;
    logic [1:0]      ch;
    logic            mix;
    logic            trap;
    logic            busy;
    logic            done;
    logic            err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multi_input_sequencer_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  multi_input_sequencer #(.N_CH(N_CH), .CNT_W(CNT_W), .MIN_GAP(MIN_GAP)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   seq_id  = 0;
  exp_t exp_q[$];

  int busy_cnt, done_cnt, trap_cnt, mix_cnt, valve_cnt, err_cnt, done_cyc;
  int first_v0, first_v2, first_mix, first_trap;
  logic [N_CH:0] last_ov;
  int closed_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [N_CH-1:0] valve, input int ch, input logic mix,
                              input logic trap, input logic busy, input logic done, input logic err);
    exp_t e;
    e.valve = valve;
    e.ch    = 2'(ch);
    e.mix   = mix;
    e.trap  = trap;
    e.busy  = busy;
    e.done  = done;
    e.err   = err;
    return e;
  endfunction

  task automatic build_trace(input logic [N_CH-1:0] mask, input int ld, input int mx,
                             input int hd, input int ab, output int ab_eff);
    int len;
    exp_q.delete();
    ab_eff = 0;
    if (mask == '0) begin
      exp_q.push_back(mk('0, 0, 0, 0, 0, 0, 1));
      return;
    end
    for (int c = 0; c < N_CH; c++) begin
      if (mask[c]) begin
        repeat (MIN_GAP) exp_q.push_back(mk('0, 0, 0, 0, 1, 0, 0));
        repeat (ld) exp_q.push_back(mk(N_CH'(1) << c, c, 0, 0, 1, 0, 0));
      end
    end
    repeat (MIN_GAP) exp_q.push_back(mk('0, 0, 0, 0, 1, 0, 0));
    repeat (mx) exp_q.push_back(mk('0, 0, 1, 0, 1, 0, 0));
    repeat (hd) exp_q.push_back(mk('0, 0, 0, 1, 1, 0, 0));
    exp_q.push_back(mk('0, 0, 0, 0, 1, 1, 0));
    len = exp_q.size();
    if (ab >= 1 && ab <= len) begin
      ab_eff = ab;
      while (exp_q.size() > ab_eff) void'(exp_q.pop_back());
      repeat (MIN_GAP) exp_q.push_back(mk('0, 0, 0, 0, 1, 0, 0));
    end
    exp_q.push_back(mk('0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic inv_check();
    logic [N_CH:0] ov;
    ov = {bus.trap_open, bus.valve_open};
    check("onehot_valves", 32'($onehot0(ov)), 32'd1);
    check("mix_vs_valve", 32'(bus.mix_en && (ov != '0)), 32'd0);
    if (ov != '0) begin
      if (last_ov != '0 && ov != last_ov)
        check("break_before_make", 32'(closed_cnt >= MIN_GAP), 32'd1);
      last_ov    = ov;
      closed_cnt = 0;
    end else if (closed_cnt < 1000) begin
      closed_cnt++;
    end
  endtask

  task automatic sample(input int cyc, input exp_t e);
    exp_t got;
    exp_t want;
    got.valve = bus.valve_open;
    got.ch    = (bus.valve_open != '0) ? bus.cur_ch : 2'd0;
    got.mix   = bus.mix_en;
    got.trap  = bus.trap_open;
    got.busy  = bus.busy;
    got.done  = bus.done;
    got.err   = bus.err;
    want = e;
    if (want.valve == '0) want.ch = 2'd0;
    check($sformatf("seq%0d_cyc%0d", seq_id, cyc), 32'(got), 32'(want));
    busy_cnt  += int'(bus.busy);
    done_cnt  += int'(bus.done);
    trap_cnt  += int'(bus.trap_open);
    mix_cnt   += int'(bus.mix_en);
    err_cnt   += int'(bus.err);
    valve_cnt += int'(bus.valve_open != '0);
    if (bus.done) done_cyc = cyc;
    if (bus.valve_open[0] && first_v0 == 0) first_v0 = cyc;
    if (bus.valve_open[2] && first_v2 == 0) first_v2 = cyc;
    if (bus.mix_en && first_mix == 0) first_mix = cyc;
    if (bus.trap_open && first_trap == 0) first_trap = cyc;
    inv_check();
  endtask

  task automatic clear_tally();
    busy_cnt = 0; done_cnt = 0; trap_cnt = 0; mix_cnt = 0; valve_cnt = 0; err_cnt = 0;
    done_cyc = 0; first_v0 = 0; first_v2 = 0; first_mix = 0; first_trap = 0;
  endtask

  task automatic randomize_inputs();
    bus.ch_en       = N_CH'($urandom);
    bus.load_cycles = CNT_W'($urandom_range(0, 9));
    bus.mix_cycles  = CNT_W'($urandom_range(0, 9));
    bus.hold_cycles = CNT_W'($urandom_range(0, 9));
  endtask

  // Drives start now; the first expected cycle is the one after the next rising edge.
  task automatic run_seq(input logic [N_CH-1:0] mask, input int ld, input int mx,
                         input int hd, input int ab);
    int ab_eff;
    int n;
    seq_id++;
    build_trace(mask, ld, mx, hd, ab, ab_eff);
    clear_tally();
    bus.start       = 1'b1;
    bus.abort       = 1'b0;
    bus.ch_en       = mask;
    bus.load_cycles = CNT_W'(ld);
    bus.mix_cycles  = CNT_W'(mx);
    bus.hold_cycles = CNT_W'(hd);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      sample(i + 1, exp_q[i]);
      bus.start = (i + 1 <= n - 1) ? 1'($urandom) : 1'b0;
      bus.abort = (i + 1 == ab_eff);
      randomize_inputs();
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.ch_en       = '0;
    bus.load_cycles = '0;
    bus.mix_cycles  = '0;
    bus.hold_cycles = '0;
    last_ov         = '0;
    closed_cnt      = 0;
    #12;
    check("reset_outputs", 32'({bus.valve_open, bus.mix_en, bus.trap_open, bus.cur_ch,
                                bus.busy, bus.done, bus.err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full run straight out of reset: start must be taken on the first edge.
    run_seq(3'b101, 4, 3, 2, 0);
    check("full_busy_cycles", 32'(busy_cnt), 32'd20);
    check("full_v0_first", 32'(first_v0), 32'd3);
    check("full_v2_first", 32'(first_v2), 32'd9);
    check("full_mix_first", 32'(first_mix), 32'd15);
    check("full_trap_first", 32'(first_trap), 32'd18);
    check("full_done_cycle", 32'(done_cyc), 32'd20);

    // Abort in cycle 4, during the ch0 load.
    run_seq(3'b101, 4, 3, 2, 4);
    check("abort_done_cnt", 32'(done_cnt), 32'd0);
    check("abort_busy_cycles", 32'(busy_cnt), 32'd6);

    run_seq(3'b000, 4, 3, 2, 0);
    check("empty_err_cnt", 32'(err_cnt), 32'd1);
    check("empty_busy_cnt", 32'(busy_cnt), 32'd0);

    run_seq(3'b010, 0, 0, 5, 0);
    check("zero_trap_cycles", 32'(trap_cnt), 32'd5);
    check("zero_valve_cycles", 32'(valve_cnt), 32'd0);
    check("zero_mix_cycles", 32'(mix_cnt), 32'd0);
    check("zero_done_cnt", 32'(done_cnt), 32'd1);

    // start together with abort in IDLE does nothing.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.ch_en = 3'b101;
    @(posedge clk);
    #1;
    check("start_abort_idle", 32'({bus.busy, bus.err}), 32'd0);
    bus.start = 1'b0;
    bus.abort = 1'b0;

    // Asynchronous reset in the middle of RELEASE.
    bus.start       = 1'b1;
    bus.ch_en       = 3'b101;
    bus.load_cycles = CNT_W'(4);
    bus.mix_cycles  = CNT_W'(3);
    bus.hold_cycles = CNT_W'(2);
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      inv_check();
    end
    check("pre_reset_trap", 32'(bus.trap_open), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({bus.valve_open, bus.mix_en, bus.trap_open,
                                      bus.busy, bus.done}), 32'd0);
    last_ov    = '0;
    closed_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(3'b101, 4, 3, 2, 0);
    check("post_reset_busy", 32'(busy_cnt), 32'd20);
    check("post_reset_done_cycle", 32'(done_cyc), 32'd20);

    for (int s = 0; s < 1500; s++) begin
      int ab;
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : 0;
      run_seq(N_CH'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), ab);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
